// File: rtl/delay_tap_sequencer_pkg.sv
// Shared definitions for the three-tap delay capture sequencer.
package delay_tap_pkg;

  localparam int NUM_TAPS  = 3;
  localparam int CNT_W_DEF = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/delay_tap_sequencer_if.sv
// Control and sample bus of the delay tap sequencer.
// master: issues start, delays and data; slave: the sequencer itself.
interface delay_tap_sequencer_if
  import delay_tap_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);

  logic             start;
  logic [CNT_W-1:0] dly1;
  logic [CNT_W-1:0] dly2;
  logic [CNT_W-1:0] dly3;
  logic             d;
  logic             q1;
  logic             q2;
  logic             q3;
  logic [2:0]       q_vld;
  logic             busy;
  logic             done;
  logic             ovr;

  modport master (
    output start, dly1, dly2, dly3, d,
    input  q1, q2, q3, q_vld, busy, done, ovr
  );

  modport slave (
    input  start, dly1, dly2, dly3, d,
    output q1, q2, q3, q_vld, busy, done, ovr
  );

endinterface

// File: rtl/delay_tap_sequencer_tap_capture.sv
// One capture tap: samples d when the edge index matches its offset.
// An accepted start clears the valid flag; an offset of zero captures on the
// accept edge itself using the incoming (not yet latched) offset. A capture
// still due for the previous sequence on a restart edge updates q, but valid
// only reflects the new sequence.
module tap_capture
  import delay_tap_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             acc,
  input  logic             run,
  input  logic [CNT_W-1:0] dly_in,
  input  logic [CNT_W-1:0] dly_lat,
  input  logic [CNT_W-1:0] cnt,
  input  logic             d,
  output logic             q,
  output logic             vld
);

  logic hit_new;
  logic hit_old;

  assign hit_new = acc && (dly_in == '0);
  assign hit_old = run && (cnt == dly_lat);

  // capture d on a matching edge and track whether this sequence has captured
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q   <= 1'b0;
      vld <= 1'b0;
    end else begin
      if (hit_new || hit_old) q <= d;
      if (acc)                vld <= hit_new;
      else if (hit_old)       vld <= 1'b1;
    end
  end

endmodule

// File: rtl/delay_tap_sequencer.sv
// Three-tap delayed-sample capture sequencer.
// A start pulse launches a sequence; each tap samples d at its programmed
// edge offset from the accept edge, and done pulses after the last capture.
// Optional build macro RETRIGGER_EN: start while busy restarts the sequence
// instead of being rejected with an ovr pulse.
//
// state | meaning
// IDLE  | waiting for start; taps hold their last captures
// RUN   | counting edges toward dmax; taps capture on offset match
module delay_tap_sequencer
  import delay_tap_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input logic                 clk,
  input logic                 rstn,
  delay_tap_sequencer_if.slave bus
);

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     dmax;
  logic [CNT_W-1:0]     dmax_nxt;
  logic [CNT_W-1:0]     dly_in  [NUM_TAPS];
  logic [CNT_W-1:0]     dly_lat [NUM_TAPS];
  logic                 acc;
  logic                 run;
  logic                 busy_r;
  logic                 done_r;
  logic                 ovr_r;
  logic [NUM_TAPS-1:0]  q;
  logic [NUM_TAPS-1:0]  vld;

  assign dly_in[0] = bus.dly1;
  assign dly_in[1] = bus.dly2;
  assign dly_in[2] = bus.dly3;

  assign run = (state == RUN);

`ifdef RETRIGGER_EN
  assign acc = bus.start;
`else
  assign acc = bus.start && (state == IDLE);
`endif

  // longest offset decides when the sequence ends
  always_comb begin
    dmax_nxt = bus.dly1;
    if (bus.dly2 > dmax_nxt) dmax_nxt = bus.dly2;
    if (bus.dly3 > dmax_nxt) dmax_nxt = bus.dly3;
  end

  // sequencing FSM with edge counter, completion and overrun pulses
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      cnt    <= '0;
      dmax   <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      ovr_r  <= 1'b0;
      for (int i = 0; i < NUM_TAPS; i++) dly_lat[i] <= '0;
    end else begin
      done_r <= 1'b0;
      ovr_r  <= 1'b0;
      if (acc) begin
        // accept edge is index 0, so the counter holds the next index
        for (int i = 0; i < NUM_TAPS; i++) dly_lat[i] <= dly_in[i];
        dmax <= dmax_nxt;
        cnt  <= {{(CNT_W-1){1'b0}}, 1'b1};
        if (dmax_nxt == '0) begin
          state  <= IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b1;
        end else begin
          state  <= RUN;
          busy_r <= 1'b1;
        end
      end else begin
        case (state)
          IDLE: begin
          end
          RUN: begin
`ifndef RETRIGGER_EN
            ovr_r <= bus.start;
`endif
            if (cnt == dmax) begin
              state  <= IDLE;
              busy_r <= 1'b0;
              done_r <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        endcase
      end
    end
  end

  for (genvar g = 0; g < NUM_TAPS; g++) begin : g_tap
    tap_capture #(.CNT_W(CNT_W)) u_tap (
      .clk     (clk),
      .rstn    (rstn),
      .acc     (acc),
      .run     (run),
      .dly_in  (dly_in[g]),
      .dly_lat (dly_lat[g]),
      .cnt     (cnt),
      .d       (bus.d),
      .q       (q[g]),
      .vld     (vld[g])
    );
  end

  assign bus.q1    = q[0];
  assign bus.q2    = q[1];
  assign bus.q3    = q[2];
  assign bus.q_vld = vld;
  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
  assign bus.ovr   = ovr_r;

endmodule
